// File: rtl/pkt_seq_pkg.sv
// Shared types and constants for the framed-packet SPI transmit sequencer.
package pkt_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CFG  = 3'd1,
        ST_LOAD = 3'd2,
        ST_GO   = 3'd3,
        ST_WAIT = 3'd4,
        ST_GAP  = 3'd5,
        ST_DONE = 3'd6
    } seq_state_e;

    localparam logic [7:0] PREAMBLE_DEF  = 8'hFF;
    localparam int         CFG_SCK_LSB   = 0;
    localparam int         CFG_SLAVE_LSB = 2;
    localparam int         CFG_MODE_LSB  = 4;
    localparam int         FRAME_BYTES   = 9;
    localparam int         CNT_W         = 4;
    localparam int         TIMER_W       = 16;

    // Packs the SPI core CONFIG byte; the two top bits are reserved as zero.
    function automatic logic [7:0] build_cfg(input logic [1:0] mode,
                                             input logic [1:0] slave,
                                             input logic [1:0] sck);
        logic [7:0] cfg;
        cfg = 8'h00;
        cfg[CFG_MODE_LSB +: 2]  = mode;
        cfg[CFG_SLAVE_LSB +: 2] = slave;
        cfg[CFG_SCK_LSB +: 2]   = sck;
        return cfg;
    endfunction

endpackage

// File: rtl/pkt_seq_timer.sv
// Loadable down-counter with a zero flag; time-shared by the inter-byte gap
// and the optional byte-done watchdog.
module pkt_seq_timer
    import pkt_seq_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    input  logic               dec,
    output logic               zero
);

    logic [TIMER_W-1:0] count_r;

    // Count register: load wins over decrement, and the count saturates at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {TIMER_W{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (dec && (count_r != {TIMER_W{1'b0}})) begin
            count_r <= count_r - {{(TIMER_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == {TIMER_W{1'b0}});

endmodule

// File: rtl/pkt_tx_sequencer.sv
// Drives CONFIG/TX/CMD strobes for a 9-byte preamble+payload frame into the SPI core.
// Optional byte-done watchdog is built when PKT_SEQ_TIMEOUT_EN is defined.
module pkt_tx_sequencer
    import pkt_seq_pkg::*;
#(
    parameter logic [7:0]  PREAMBLE = PREAMBLE_DEF,
    parameter int unsigned GAP_CYC  = 16
`ifdef PKT_SEQ_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 4096
`endif
) (
    input  logic        i_PCLK,
    input  logic        i_PRESETn,
    input  logic        i_start,
    input  logic [63:0] i_pkt,
    input  logic [1:0]  i_mode,
    input  logic [1:0]  i_slave,
    input  logic [1:0]  i_sck,
    input  logic        i_abort,
    input  logic        i_byte_done,
    output logic        o_cfg_wr,
    output logic [7:0]  o_cfg_data,
    output logic        o_tx_wr,
    output logic [7:0]  o_tx_data,
    output logic        o_cmd_go,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err
);

    localparam logic               GAP_EN    = (GAP_CYC != 32'd0);
    localparam logic [TIMER_W-1:0] GAP_LOAD  = GAP_EN ? TIMER_W'(GAP_CYC - 32'd1) : {TIMER_W{1'b0}};
    localparam logic [CNT_W-1:0]   LAST_BYTE = CNT_W'(FRAME_BYTES - 1);
`ifdef PKT_SEQ_TIMEOUT_EN
    localparam logic [TIMER_W-1:0] TIMEOUT_LOAD = TIMER_W'(TIMEOUT_CYC - 32'd1);
`endif

    seq_state_e         state_r, fsm_next_s, next_s;
    logic [71:0]        frame_r;
    logic [CNT_W-1:0]   byte_cnt_r;
    logic [7:0]         cfg_data_r;
    logic               accept_s, advance_s, abort_s;
    logic               timer_load_s, timer_dec_s, timer_zero_s;
    logic [TIMER_W-1:0] timer_val_s;
    logic               cfg_wr_r, tx_wr_r, cmd_go_r, busy_r, done_r;
`ifdef PKT_SEQ_TIMEOUT_EN
    logic               err_s, err_r;
`endif

    pkt_seq_timer u_timer (
        .clk      (i_PCLK),
        .rst_n    (i_PRESETn),
        .load     (timer_load_s),
        .load_val (timer_val_s),
        .dec      (timer_dec_s),
        .zero     (timer_zero_s)
    );

    assign abort_s = i_abort && (state_r != ST_IDLE);

    // Next-state and timer control; abort overrides whatever the state decided.
    always_comb begin
        fsm_next_s   = state_r;
        accept_s     = 1'b0;
        advance_s    = 1'b0;
        timer_load_s = 1'b0;
        timer_val_s  = {TIMER_W{1'b0}};
        timer_dec_s  = 1'b0;
`ifdef PKT_SEQ_TIMEOUT_EN
        err_s        = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                if (i_start) begin
                    fsm_next_s = ST_CFG;
                    accept_s   = 1'b1;
                end else begin
                    fsm_next_s = ST_IDLE;
                end
            end
            ST_CFG:  fsm_next_s = ST_LOAD;
            ST_LOAD: fsm_next_s = ST_GO;
            ST_GO: begin
                fsm_next_s = ST_WAIT;
`ifdef PKT_SEQ_TIMEOUT_EN
                timer_load_s = 1'b1;
                timer_val_s  = TIMEOUT_LOAD;
`endif
            end
            ST_WAIT: begin
                if (i_byte_done) begin
                    if (byte_cnt_r == LAST_BYTE) begin
                        fsm_next_s = ST_DONE;
                    end else if (GAP_EN) begin
                        advance_s    = 1'b1;
                        fsm_next_s   = ST_GAP;
                        timer_load_s = 1'b1;
                        timer_val_s  = GAP_LOAD;
                    end else begin
                        advance_s  = 1'b1;
                        fsm_next_s = ST_CFG;
                    end
                end else begin
`ifdef PKT_SEQ_TIMEOUT_EN
                    if (timer_zero_s) begin
                        fsm_next_s = ST_IDLE;
                        err_s      = 1'b1;
                    end else begin
                        timer_dec_s = 1'b1;
                    end
`else
                    fsm_next_s = ST_WAIT;
`endif
                end
            end
            ST_GAP: begin
                if (timer_zero_s) begin
                    fsm_next_s = ST_CFG;
                end else begin
                    timer_dec_s = 1'b1;
                end
            end
            ST_DONE: fsm_next_s = ST_IDLE;
            default: fsm_next_s = ST_IDLE;
        endcase
        if (abort_s) begin
            next_s = ST_IDLE;
        end else begin
            next_s = fsm_next_s;
        end
    end

    // State register.
    always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
        if (!i_PRESETn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Frame, byte counter and CONFIG latch; all hold while idle.
    always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
        if (!i_PRESETn) begin
            frame_r    <= 72'h0;
            byte_cnt_r <= {CNT_W{1'b0}};
            cfg_data_r <= 8'h00;
        end else if (accept_s) begin
            frame_r    <= {PREAMBLE, i_pkt};
            byte_cnt_r <= {CNT_W{1'b0}};
            cfg_data_r <= build_cfg(i_mode, i_slave, i_sck);
        end else if (advance_s && !abort_s) begin
            frame_r    <= {frame_r[63:0], 8'h00};
            byte_cnt_r <= byte_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            frame_r    <= frame_r;
            byte_cnt_r <= byte_cnt_r;
            cfg_data_r <= cfg_data_r;
        end
    end

    // Strobes decoded from the next state so each lands in its own state's cycle.
    always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
        if (!i_PRESETn) begin
            cfg_wr_r <= 1'b0;
            tx_wr_r  <= 1'b0;
            cmd_go_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            cfg_wr_r <= (next_s == ST_CFG);
            tx_wr_r  <= (next_s == ST_LOAD);
            cmd_go_r <= (next_s == ST_GO);
            busy_r   <= (next_s != ST_IDLE);
            done_r   <= (next_s == ST_DONE);
        end
    end

`ifdef PKT_SEQ_TIMEOUT_EN
    // Watchdog expiry pulse; suppressed when an abort arrives in the same cycle.
    always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
        if (!i_PRESETn) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_s && !abort_s;
        end
    end
    assign o_err = err_r;
`else
    assign o_err = 1'b0;
`endif

    assign o_cfg_wr   = cfg_wr_r;
    assign o_cfg_data = cfg_data_r;
    assign o_tx_wr    = tx_wr_r;
    assign o_tx_data  = frame_r[71:64];
    assign o_cmd_go   = cmd_go_r;
    assign o_busy     = busy_r;
    assign o_done     = done_r;

endmodule

// File: tb/tb_pkt_tx_sequencer.sv
// Scoreboard bench for pkt_tx_sequencer: one instance with a 16-cycle gap, one with no gap.
module tb_pkt_tx_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, start_s, bd_s, abort_s, sel;
    logic [63:0] pkt_s;
    logic [1:0]  mode_s, slave_s, sck_s;

    logic       cfg_wr_a, tx_wr_a, cmd_go_a, busy_a, done_a, err_a;
    logic [7:0] cfg_data_a, tx_data_a;
    logic       cfg_wr_b, tx_wr_b, cmd_go_b, busy_b, done_b, err_b;
    logic [7:0] cfg_data_b, tx_data_b;

    logic       cfg_wr_v, tx_wr_v, cmd_go_v, busy_v, done_v, err_v;
    logic [7:0] cfg_data_v, tx_data_v;

    int tests_run = 0, tests_failed = 0;
    int cmd_cnt = 0, done_cnt = 0, err_cnt = 0;
    logic [7:0] exp_tx[$];
    logic [7:0] exp_cfg[$];

    always #5 clk = ~clk;

    pkt_tx_sequencer #(
        .GAP_CYC(16)
`ifdef PKT_SEQ_TIMEOUT_EN
        , .TIMEOUT_CYC(64)
`endif
    ) u_dut (
        .i_PCLK(clk), .i_PRESETn(rst_n), .i_start(start_s & ~sel), .i_pkt(pkt_s),
        .i_mode(mode_s), .i_slave(slave_s), .i_sck(sck_s),
        .i_abort(abort_s & ~sel), .i_byte_done(bd_s & ~sel),
        .o_cfg_wr(cfg_wr_a), .o_cfg_data(cfg_data_a), .o_tx_wr(tx_wr_a),
        .o_tx_data(tx_data_a), .o_cmd_go(cmd_go_a), .o_busy(busy_a),
        .o_done(done_a), .o_err(err_a)
    );

    pkt_tx_sequencer #(
        .GAP_CYC(0)
`ifdef PKT_SEQ_TIMEOUT_EN
        , .TIMEOUT_CYC(64)
`endif
    ) u_dut_nogap (
        .i_PCLK(clk), .i_PRESETn(rst_n), .i_start(start_s & sel), .i_pkt(pkt_s),
        .i_mode(mode_s), .i_slave(slave_s), .i_sck(sck_s),
        .i_abort(abort_s & sel), .i_byte_done(bd_s & sel),
        .o_cfg_wr(cfg_wr_b), .o_cfg_data(cfg_data_b), .o_tx_wr(tx_wr_b),
        .o_tx_data(tx_data_b), .o_cmd_go(cmd_go_b), .o_busy(busy_b),
        .o_done(done_b), .o_err(err_b)
    );

    assign cfg_wr_v   = sel ? cfg_wr_b   : cfg_wr_a;
    assign tx_wr_v    = sel ? tx_wr_b    : tx_wr_a;
    assign cmd_go_v   = sel ? cmd_go_b   : cmd_go_a;
    assign busy_v     = sel ? busy_b     : busy_a;
    assign done_v     = sel ? done_b     : done_a;
    assign err_v      = sel ? err_b      : err_a;
    assign cfg_data_v = sel ? cfg_data_b : cfg_data_a;
    assign tx_data_v  = sel ? tx_data_b  : tx_data_a;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard: every CONFIG/TX write must match the next queued expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (cfg_wr_v) begin
                if (exp_cfg.size() == 0) check_eq("cfg_extra", 64'd1, 64'd0);
                else check_eq("cfg_data", 64'(cfg_data_v), 64'(exp_cfg.pop_front()));
            end
            if (tx_wr_v) begin
                if (exp_tx.size() == 0) check_eq("tx_extra", 64'd1, 64'd0);
                else check_eq("tx_data", 64'(tx_data_v), 64'(exp_tx.pop_front()));
            end
            if (sel ? busy_a : busy_b) check_eq("idle_dut_busy", 64'd1, 64'd0);
            if (cmd_go_v) cmd_cnt++;
            if (done_v) done_cnt++;
            if (err_v) err_cnt++;
        end
    end

    task automatic push_expect(input logic [63:0] pkt, input logic [1:0] mode,
                               input logic [1:0] slave, input logic [1:0] sck, input int n);
        logic [71:0] f;
        f = {8'hFF, pkt};
        for (int i = 0; i < n; i++) begin
            exp_tx.push_back(f[71-8*i -: 8]);
            exp_cfg.push_back({2'b00, mode, slave, sck});
        end
    endtask

    task automatic wait_go();
        int j;
        j = 0;
        while (!cmd_go_v && j < 64) begin
            @(negedge clk);
            j++;
        end
        check_eq("go_seen", 64'(cmd_go_v), 64'd1);
    endtask

    // Runs one frame starting at the current negedge; abort_b < 0 means no abort.
    task automatic run_frame(input logic [63:0] pkt, input logic [1:0] mode, input logic [1:0] slave,
                             input logic [1:0] sck, input int abort_b, input bit stray,
                             input bit mid_start, input bit start_in_done, input int gap);
        int nsend, k;
        nsend = (abort_b >= 0) ? abort_b + 1 : 9;
        push_expect(pkt, mode, slave, sck, nsend);
        cmd_cnt = 0;
        done_cnt = 0;
        pkt_s = pkt; mode_s = mode; slave_s = slave; sck_s = sck;
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        check_eq("cfg_lat", 64'(cfg_wr_v), 64'd1);
        if (stray) begin
            bd_s = 1'b1;
            @(negedge clk);
            @(negedge clk);
            bd_s = 1'b0;
        end
        for (int b = 0; b < 9; b++) begin
            wait_go();
            for (int w = 0; w < 5; w++) begin
                if (mid_start && b == 2 && w == 1) begin
                    start_s = 1'b1;
                    pkt_s = 64'h0123012301230123;
                end else begin
                    start_s = 1'b0;
                end
                @(negedge clk);
            end
            bd_s = 1'b1;
            abort_s = (b == abort_b);
            @(negedge clk);
            bd_s = 1'b0;
            if (b == abort_b) begin
                abort_s = 1'b0;
                check_eq("abort_busy", 64'(busy_v), 64'd0);
                repeat (30) @(negedge clk);
                check_eq("abort_go_cnt", 64'(cmd_cnt), 64'(nsend));
                check_eq("abort_no_done", 64'(done_cnt), 64'd0);
                check_eq("abort_tx_left", 64'(exp_tx.size()), 64'd0);
                return;
            end
            if (b == 8) begin
                check_eq("done_lat", 64'(done_v), 64'd1);
                check_eq("busy_at_done", 64'(busy_v), 64'd1);
                start_s = start_in_done;
                @(negedge clk);
                start_s = 1'b0;
                check_eq("done_pulse", 64'(done_v), 64'd0);
                check_eq("busy_fall", 64'(busy_v), 64'd0);
                check_eq("done_cnt", 64'(done_cnt), 64'd1);
                check_eq("go_cnt", 64'(cmd_cnt), 64'd9);
                check_eq("tx_left", 64'(exp_tx.size()), 64'd0);
                return;
            end
            k = 1;
            while (!cfg_wr_v && k < 60) begin
                bd_s = (stray && k == 5);
                @(negedge clk);
                k++;
            end
            bd_s = 1'b0;
            check_eq("gap_len", 64'(k), 64'(gap + 1));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; start_s = 1'b0; bd_s = 1'b0; abort_s = 1'b0; sel = 1'b0;
        pkt_s = 64'h0; mode_s = 2'b00; slave_s = 2'b00; sck_s = 2'b00;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", 64'(busy_a), 64'd0);
        check_eq("rst_strobes", 64'({cfg_wr_a, tx_wr_a, cmd_go_a}), 64'd0);
        check_eq("rst_done_err", 64'({done_a, err_a}), 64'd0);
        check_eq("rst_cfg_data", 64'(cfg_data_a), 64'd0);
        check_eq("rst_tx_data", 64'(tx_data_a), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_frame(64'h8123456789ABCD0F, 2'b00, 2'b11, 2'b01, -1, 1'b0, 1'b0, 1'b0, 16);
        repeat (4) @(negedge clk);
        run_frame(64'hDEADBEEF01234567, 2'b10, 2'b01, 2'b11, -1, 1'b1, 1'b1, 1'b1, 16);
        run_frame({$urandom, $urandom}, 2'b01, 2'b10, 2'b00, -1, 1'b0, 1'b0, 1'b0, 16);
        repeat (3) @(negedge clk);
        run_frame(64'h1122334455667788, 2'b11, 2'b00, 2'b10, 3, 1'b0, 1'b0, 1'b0, 16);

        sel = 1'b1;
        repeat (2) @(negedge clk);
        run_frame(64'hA5A55A5AC3C33C3C, 2'b01, 2'b01, 2'b01, -1, 1'b0, 1'b0, 1'b0, 0);
        sel = 1'b0;
        repeat (2) @(negedge clk);

        // Asynchronous reset in the middle of a frame.
        push_expect(64'hFEDCBA9876543210, 2'b10, 2'b10, 2'b10, 9);
        pkt_s = 64'hFEDCBA9876543210; mode_s = 2'b10; slave_s = 2'b10; sck_s = 2'b10;
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        wait_go();
        #3 rst_n = 1'b0;
        #1;
        check_eq("arst_busy", 64'(busy_a), 64'd0);
        check_eq("arst_go", 64'(cmd_go_a), 64'd0);
        check_eq("arst_cfg_data", 64'(cfg_data_a), 64'd0);
        check_eq("arst_tx_data", 64'(tx_data_a), 64'd0);
        exp_tx.delete();
        exp_cfg.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_busy", 64'(busy_a), 64'd0);
        run_frame(64'h0F0E0D0C0B0A0908, 2'b00, 2'b01, 2'b10, -1, 1'b0, 1'b0, 1'b0, 16);
        repeat (2) @(negedge clk);

        // Byte-done withheld.
        push_expect(64'h5555AAAA5555AAAA, 2'b00, 2'b00, 2'b00, 1);
        pkt_s = 64'h5555AAAA5555AAAA; mode_s = 2'b00; slave_s = 2'b00; sck_s = 2'b00;
        err_cnt = 0;
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        wait_go();
`ifdef PKT_SEQ_TIMEOUT_EN
        begin
            int k;
            k = 0;
            while (!err_v && k < 200) begin
                @(negedge clk);
                k++;
            end
            check_eq("err_lat", 64'(k), 64'd65);
            check_eq("err_busy", 64'(busy_v), 64'd0);
            @(negedge clk);
            check_eq("err_pulse", 64'(err_v), 64'd0);
            check_eq("err_cnt", 64'(err_cnt), 64'd1);
        end
`else
        repeat (100) @(negedge clk);
        check_eq("wait_hold_busy", 64'(busy_v), 64'd1);
        check_eq("no_err", 64'(err_cnt), 64'd0);
        abort_s = 1'b1;
        @(negedge clk);
        abort_s = 1'b0;
        check_eq("hold_abort_busy", 64'(busy_v), 64'd0);
`endif
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pkt_tx_sequencer.md
# pkt_tx_sequencer

Sequences transmission of one framed packet through the SPI master core behind the APB interface. Each frame is the 8-bit preamble followed by a 64-bit payload, sent MSB-first as 9 single-byte SPI transfers. For every byte the block issues the CONFIG write, the TX write and the CMD "go" strobe that the bus host would otherwise issue. It then waits for the core's byte-done handshake and inserts a programmable inter-byte gap, so firmware issues a single start instead of 27 APB writes.

## Interface
- PREAMBLE, 8'hFF: first byte of every frame.
- GAP_CYC, 16: idle i_PCLK cycles between byte-done and the next byte's CONFIG write; 0 means no gap.
- TIMEOUT_CYC, 4096: byte-done watchdog limit. Used only with PKT_SEQ_TIMEOUT_EN.

Ports:
- i_PCLK  in  1  system clock; all logic is rising-edge.
- i_PRESETn  in  1  asynchronous, active-low reset.
- i_start  in  1  one-cycle request; sampled only in IDLE.
- i_pkt  in  64  payload, latched on an accepted start.
- i_mode  in  2  SPI mode, latched on an accepted start.
- i_slave  in  2  slave select, latched on an accepted start.
- i_sck  in  2  SCK divider code, latched on an accepted start.
- i_abort  in  1  synchronous abort.
- i_byte_done  in  1  one-cycle pulse from the SPI core when a byte completes.
- o_cfg_wr  out  1  CONFIG register write strobe.
- o_cfg_data  out  8  CONFIG value, {2'b00, mode, slave, sck}.
- o_tx_wr  out  1  TX register write strobe.
- o_tx_data  out  8  current frame byte.
- o_cmd_go  out  1  CMD register "start transfer" strobe.
- o_busy  out  1  high whenever state is not IDLE.
- o_done  out  1  one-cycle pulse when the frame completes.
- o_err  out  1  one-cycle pulse on watchdog expiry.

## Operation
- Frame register is 72 bits, {PREAMBLE, i_pkt}. It shifts left by 8 after each byte-done. o_tx_data is always frame[71:64].
- Byte counter runs 0..8. Byte 0 is the preamble; byte 8 is i_pkt[7:0].
- States: IDLE, CFG, LOAD, GO, WAIT, GAP, DONE.
- IDLE -> CFG on i_start. Payload, mode, slave and sck are captured in the same cycle.
- CFG -> LOAD -> GO -> WAIT, one cycle each. Each state asserts only its own strobe: o_cfg_wr, o_tx_wr, o_cmd_go respectively.
- WAIT -> GAP on i_byte_done when byte counter < 8; the counter increments and the frame shifts.
- WAIT -> DONE on i_byte_done when byte counter = 8.
- GAP counts GAP_CYC cycles, then goes to CFG. With GAP_CYC = 0, WAIT goes straight to CFG.
- DONE asserts o_done for one cycle, then goes to IDLE.
- Outside WAIT, i_byte_done is ignored.
- Outside IDLE, i_start is ignored, including the DONE cycle.
- i_abort in any non-IDLE state: next state is IDLE, with no o_done and no further strobes.
- i_abort has priority over i_byte_done in the same cycle.
- In IDLE, o_cfg_data, o_tx_data and the latched configuration hold their last values.

## Timing
- Reset value of every output is 0. State resets to IDLE, counters to 0, and the frame register to 0.
- Start accepted at cycle 0. o_cfg_wr is high at cycle 1, o_tx_wr at cycle 2, o_cmd_go at cycle 3.
- From byte-done to the next o_cfg_wr is GAP_CYC + 1 cycles.
- From the last byte-done to o_done is 1 cycle. o_busy falls the cycle after o_done.
- Reset asserted mid-frame forces all outputs to 0 immediately (asynchronously). Operation resumes from IDLE.

## Configuration
- PKT_SEQ_TIMEOUT_EN defined:
  - A watchdog counts cycles spent in WAIT.
  - When the count reaches TIMEOUT_CYC, o_err pulses for one cycle and the state goes to IDLE without o_done.
  - The watchdog reloads on every entry to WAIT.
- PKT_SEQ_TIMEOUT_EN undefined:
  - WAIT waits indefinitely.
  - o_err is tied to 0.
  - No watchdog logic is present.

## Structure
- Package pkt_seq_pkg holds:
  - the state enum;
  - the default PREAMBLE;
  - the CONFIG byte field positions;
  - the frame byte count (9).
- Sub-module pkt_seq_timer is a loadable down-counter with a zero flag. It is shared by GAP and, under the macro, the watchdog; the two are never active at the same time.

## Test plan
- Start with i_pkt = 64'h8123456789ABCD0F, mode 00, slave 11, sck 01, GAP_CYC = 16, and byte-done 5 cycles after each o_cmd_go.
  - o_tx_data sequence is FF, 81, 23, 45, 67, 89, AB, CD, 0F.
  - o_cfg_data = 8'h0D on all 9 writes.
  - Exactly one o_done.
- With GAP_CYC = 0: next o_cfg_wr comes exactly 1 cycle after each byte-done.
- i_abort asserted in the same cycle as the 4th byte-done:
  - no further strobes;
  - o_done never pulses;
  - o_busy is low next cycle.
- i_start pulsed mid-frame and in the DONE cycle:
  - both are ignored;
  - a start one cycle after DONE begins a new frame with o_cfg_wr 1 cycle later.
- Stray i_byte_done pulses in CFG, LOAD and GAP: no state change, and the byte count is unaffected.
- With PKT_SEQ_TIMEOUT_EN and TIMEOUT_CYC = 64, byte-done withheld:
  - o_err pulses 64 cycles after entering WAIT;
  - the block returns to IDLE;
  - without the macro, o_busy stays high.
